axi_burst_ram_slave: RTL and testbench

- AXI4 (subset) burst responder backed by an on-chip single-port RAM; it is the memory-side counterpart to the DDR self-test master.
- Accepts INCR write bursts (AW/W/B) and read bursts (AR/R), one transaction at a time.
- Used as a fast stand-in for the DDR controller in simulation and FPGA bring-up, so the self-test master can be exercised without SDRAM.
- Port set matches the master's subset exactly: no id, size, burst or resp signals.

---
 rtl/axi_ram_pkg.sv | 14 +
 rtl/sp_ram.sv | 37 +++
 rtl/axi_burst_ram_slave.sv | 170 +++++++++++++++++
 tb/tb_axi_burst_ram_slave.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_pkg.sv
// Shared types and widths for the AXI burst RAM responder.
package axi_ram_pkg;

  localparam int unsigned LEN_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WRESP,
    RFETCH,
    RD
  } state_e;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with a registered, resettable read port.
module sp_ram #(
  parameter int unsigned MEM_AW  = 10,
  parameter int unsigned D_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [MEM_AW-1:0]  addr_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  output logic [D_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] rdata_q;

  // Array is deliberately not reset; writes are suppressed while in reset.
  always_ff @(posedge clk) begin
    if (we_i && !rst) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_burst_ram_slave.sv
// AXI4-subset INCR burst responder over an on-chip RAM, one transaction at a time.
module axi_burst_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int unsigned A_WIDTH = 26,
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned D_LEVEL = 1,
  parameter int unsigned MEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               awvalid,
  output logic               awready,
  input  logic [A_WIDTH-1:0] awaddr,
  input  logic [7:0]         awlen,
  input  logic               wvalid,
  output logic               wready,
  input  logic               wlast,
  input  logic [D_WIDTH-1:0] wdata,
  output logic               bvalid,
  input  logic               bready,
  input  logic               arvalid,
  output logic               arready,
  input  logic [A_WIDTH-1:0] araddr,
  input  logic [7:0]         arlen,
  output logic               rvalid,
  input  logic               rready,
  output logic               rlast,
  output logic [D_WIDTH-1:0] rdata,
  output logic               proto_err
);

  localparam int unsigned LO = D_LEVEL;
  localparam int unsigned HI = MEM_AW + D_LEVEL - 1;

  state_e             state_q, state_d;
  logic [MEM_AW-1:0]  ptr_q, ptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               perr_q, perr_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               bvalid_q, bvalid_d;
  logic               rvalid_q, rvalid_d;
  logic               rlast_q, rlast_d;
  logic               ram_we, ram_re;
  logic [D_WIDTH-1:0] ram_rdata;
  logic               at_len;
  logic               unused_addr;

  // Only the word-index slice of each address reaches the RAM.
  assign unused_addr = ^{awaddr, araddr};
  assign at_len      = (cnt_q == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      perr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      perr_q    <= perr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // Next state and burst bookkeeping; the write channel wins a same-cycle tie.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (awready_q && awvalid) begin
          ptr_d   = awaddr[HI:LO];
          cnt_d   = '0;
          len_d   = awlen;
          state_d = WR;
        end else if (awready_q && arvalid) begin
          ptr_d   = araddr[HI:LO];
          cnt_d   = '0;
          len_d   = arlen;
          state_d = RFETCH;
        end
      end
      WR: begin
        if (wvalid && wready_q) begin
          ptr_d = ptr_q + MEM_AW'(1);
          cnt_d = cnt_q + LEN_W'(1);
          if (wlast != at_len) begin
            perr_d = 1'b1;
          end
          if (wlast || at_len) begin
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        if (bready) begin
          state_d = IDLE;
        end
      end
      RFETCH: begin
        ptr_d   = ptr_q + MEM_AW'(1);
        state_d = RD;
      end
      RD: begin
        if (rready) begin
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + MEM_AW'(1);
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state; RAM strobes decode the current one.
  always_comb begin
    awready_d = (state_d == IDLE);
    wready_d  = (state_d == WR);
    bvalid_d  = (state_d == WRESP);
    rvalid_d  = (state_d == RD);
    rlast_d   = (state_d == RD) && (cnt_d == len_d);
    ram_we    = (state_q == WR) && wvalid && wready_q;
    ram_re    = (state_q == RFETCH) || ((state_q == RD) && rready && !rlast_q);
  end

  sp_ram #(
    .MEM_AW  (MEM_AW),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ptr_q),
    .wdata_i (wdata),
    .rdata_o (ram_rdata)
  );

  assign awready   = awready_q;
  assign arready   = awready_q && !awvalid;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign rvalid    = rvalid_q;
  assign rlast     = rlast_q;
  assign rdata     = ram_rdata;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Directed bench for axi_burst_ram_slave: bursts, stalls, arbitration, protocol error, aliasing, reset.
module tb_axi_burst_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready;
  logic [25:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid, wready, wlast;
  logic [15:0] wdata;
  logic        bvalid, bready;
  logic        arvalid, arready;
  logic [25:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid, rready, rlast;
  logic [15:0] rdata;
  logic        proto_err;

  int n_vec = 0;
  int n_err = 0;

  axi_burst_ram_slave dut (
    .clk       (clk),
    .rst       (rst),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .wvalid    (wvalid),
    .wready    (wready),
    .wlast     (wlast),
    .wdata     (wdata),
    .bvalid    (bvalid),
    .bready    (bready),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arlen     (arlen),
    .rvalid    (rvalid),
    .rready    (rready),
    .rlast     (rlast),
    .rdata     (rdata),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Beat i carries base + 2*i; wlast is driven on beat index last_beat.
  task automatic wr_burst(input logic [25:0] addr, input logic [7:0] len,
                          input logic [15:0] base, input int last_beat, input logic exp_perr);
    int nb;
    awvalid = 1'b1; awaddr = addr; awlen = len;
    #1;
    chk1("awready_idle", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    nb = (int'(len) < last_beat) ? int'(len) + 1 : last_beat + 1;
    for (int i = 0; i < nb; i++) begin
      wvalid = 1'b1;
      wdata  = base + 16'(2 * i);
      wlast  = (i == last_beat);
      chk1("wready_beat", wready, 1'b1);
      chk1("bvalid_early", bvalid, 1'b0);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk1("bvalid_rise", bvalid, 1'b1);
    chk1("wready_after", wready, 1'b0);
    chk1("proto_err_wr", proto_err, exp_perr);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk1("bvalid_clear", bvalid, 1'b0);
  endtask

  // Expects beat i to return base + 2*i; toggle inserts a stall cycle before every beat.
  task automatic rd_burst(input logic [25:0] addr, input logic [7:0] len,
                          input logic [15:0] base, input bit toggle);
    logic [15:0] exp_d;
    logic        exp_l;
    arvalid = 1'b1; araddr = addr; arlen = len;
    #1;
    chk1("arready_idle", arready, 1'b1);
    tick();
    arvalid = 1'b0;
    chk1("rvalid_fetch", rvalid, 1'b0);
    tick();
    chk1("rvalid_first", rvalid, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      exp_d = base + 16'(2 * i);
      exp_l = (i == int'(len));
      if (toggle) begin
        rready = 1'b0;
        tick();
        chk1("rvalid_stall", rvalid, 1'b1);
        chk16("rdata_stall", rdata, exp_d);
        chk1("rlast_stall", rlast, exp_l);
      end
      rready = 1'b1;
      chk1("rvalid_beat", rvalid, 1'b1);
      chk16("rdata_beat", rdata, exp_d);
      chk1("rlast_beat", rlast, exp_l);
      tick();
    end
    rready = 1'b0;
    chk1("rvalid_done", rvalid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    awvalid = 1'b0; awaddr = '0; awlen = '0;
    wvalid = 1'b0; wlast = 1'b0; wdata = '0; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; arlen = '0; rready = 1'b0;
    tick();
    tick();
    chk1("rst_awready", awready, 1'b0);
    chk1("rst_arready", arready, 1'b0);
    chk1("rst_wready", wready, 1'b0);
    chk1("rst_bvalid", bvalid, 1'b0);
    chk1("rst_rvalid", rvalid, 1'b0);
    chk1("rst_rlast", rlast, 1'b0);
    chk16("rst_rdata", rdata, 16'h0000);
    chk1("rst_proto_err", proto_err, 1'b0);
    rst = 1'b0;
    tick();
    chk1("idle_awready", awready, 1'b1);

    // Eight-beat write at byte 0x10 (word 8), then full-rate readback
    wr_burst(26'h10, 8'd7, 16'h0008, 7, 1'b0);
    rd_burst(26'h10, 8'd7, 16'h0008, 1'b0);

    // Simultaneous AW and AR: write first, read only after B
    awvalid = 1'b1; awaddr = 26'h100; awlen = 8'd0;
    arvalid = 1'b1; araddr = 26'h10;  arlen = 8'd7;
    #1;
    chk1("tie_awready", awready, 1'b1);
    chk1("tie_arready", arready, 1'b0);
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 16'h1234; wlast = 1'b1;
    chk1("tie_arready_wr", arready, 1'b0);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    chk1("tie_bvalid", bvalid, 1'b1);
    chk1("tie_arready_b", arready, 1'b0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    // Same read as before with rready toggling every cycle
    rd_burst(26'h10, 8'd7, 16'h0008, 1'b1);

    // Early wlast on beat 3 of an awlen=7 burst
    wr_burst(26'h40, 8'd7, 16'h1000, 2, 1'b1);
    rd_burst(26'h40, 8'd2, 16'h1000, 1'b0);
    chk1("proto_err_sticky", proto_err, 1'b1);

    // Pointer wraps from word 1023 to word 0; 0x801 aliases word 0
    wr_burst(26'h7FE, 8'd1, 16'hBEEF, 1, 1'b1);
    rd_burst(26'h000, 8'd0, 16'hBEF1, 1'b0);
    rd_burst(26'h801, 8'd0, 16'hBEF1, 1'b0);
    rd_burst(26'h7FE, 8'd0, 16'hBEEF, 1'b0);

    // Reset in the middle of a stalled read
    arvalid = 1'b1; araddr = 26'h10; arlen = 8'd7;
    tick();
    arvalid = 1'b0;
    tick();
    chk1("midrd_rvalid", rvalid, 1'b1);
    chk16("midrd_rdata", rdata, 16'h0008);
    rst = 1'b1;
    tick();
    chk1("midrd_rst_rvalid", rvalid, 1'b0);
    chk1("midrd_rst_rlast", rlast, 1'b0);
    chk16("midrd_rst_rdata", rdata, 16'h0000);
    chk1("midrd_rst_proto_err", proto_err, 1'b0);
    rst = 1'b0;
    tick();
    chk1("post_rst_awready", awready, 1'b1);
    chk1("post_rst_rvalid", rvalid, 1'b0);
    // RAM contents survive reset
    rd_burst(26'h12, 8'd1, 16'h000A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
